// File: rtl/linterp_ramp.sv
// -----------------------------------------------------------------------------
// linterp_ramp
//
// First-order linear interpolating upsampler. It collects natural-order IFFT
// bursts of Nfft complex samples. On each out_ce strobe it moves every one of
// the Nfft parallel output lanes from the previous burst's value toward the
// new burst's value. The move takes 2**LR equal steps.
//
// Optional build macro:
//   LINTERP_ROUND_EN  - when defined, the output is rounded half up:
//                       (acc + 2**(LR-1)) >>> LR.
//                       When undefined, the output is truncated toward minus
//                       infinity: acc >>> LR.
//                       Latency is the same in both builds.
//
// Parameters:
//   dwidth  signed sample width, real and imag
//   Nfft    samples per burst = number of output lanes (>= 2)
//   iwidth  burst index width
//   LR      log2 of the upsample factor R = 2**LR (>= 1)
//
// Ports:
//   clk        sole clock
//   resetn     synchronous active-low reset
//   dv_in      input sample valid
//   index_in   position of the sample within its burst
//   din_real   input sample, real part, signed
//   din_imag   input sample, imag part, signed
//   out_ce     output-rate step strobe
//   dout_real  interpolated lanes, real part, signed
//   dout_imag  interpolated lanes, imag part, signed
//   dout_valid high from the first completed burst until reset
//   phase_out  current interpolation step mu, 0..R
//   overrun    1-cycle pulse: a burst was loaded before the ramp finished
//   underrun   1-cycle pulse: out_ce arrived with no ramp left to run
// -----------------------------------------------------------------------------
module linterp_ramp #(
    parameter int dwidth = 16,
    parameter int Nfft   = 32,
    parameter int iwidth = $clog2(Nfft),
    parameter int LR     = 3
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        dv_in,
    input  logic [iwidth-1:0]           index_in,
    input  logic signed [dwidth-1:0]    din_real,
    input  logic signed [dwidth-1:0]    din_imag,
    input  logic                        out_ce,
    output logic [Nfft-1:0][dwidth-1:0] dout_real,
    output logic [Nfft-1:0][dwidth-1:0] dout_imag,
    output logic                        dout_valid,
    output logic [LR:0]                 phase_out,
    output logic                        overrun,
    output logic                        underrun
);

    // Accumulator width. It holds target <<< LR and every intermediate
    // point of a ramp, so it can never overflow.
    localparam int AW  = dwidth + LR + 1;
    localparam int DW1 = dwidth + 1;

    localparam logic [LR:0]       MU_R     = {1'b1, {LR{1'b0}}};
    localparam logic [LR:0]       MU_LAST  = MU_R - (LR+1)'(1);
    localparam logic [iwidth-1:0] IDX_LAST = iwidth'(Nfft - 1);

    typedef enum logic [1:0] {
        IDLE,   // mu == R, no burst seen since reset
        RAMP,   // mu <  R
        DONE    // mu == R, output parked on the current target
    } state_t;

    // -------------------------------------------------------------------------
    // Arithmetic helpers
    // -------------------------------------------------------------------------

    // Per-step increment: new target minus old target, one bit wider than a
    // sample so that the full-scale swing fits.
    function automatic logic signed [DW1-1:0] lane_delta(
        input logic signed [dwidth-1:0] nxt,
        input logic signed [dwidth-1:0] cur
    );
        lane_delta = {nxt[dwidth-1], nxt} - {cur[dwidth-1], cur};
    endfunction

    // Ramp starting point: old target scaled by R.
    function automatic logic signed [AW-1:0] acc_init(
        input logic signed [dwidth-1:0] t
    );
        acc_init = {t[dwidth-1], t, {LR{1'b0}}};
    endfunction

    function automatic logic signed [AW-1:0] acc_step(
        input logic signed [AW-1:0]  a,
        input logic signed [DW1-1:0] d
    );
        acc_step = a + {{LR{d[DW1-1]}}, d};
    endfunction

`ifdef LINTERP_ROUND_EN
    localparam logic signed [AW-1:0] HALF = AW'(1) << (LR - 1);

    // Round half up. acc + HALF stays in range: the largest acc is
    // max_sample << LR, and adding HALF still shifts down to max_sample.
    function automatic logic signed [dwidth-1:0] scale_out(
        input logic signed [AW-1:0] a
    );
        scale_out = dwidth'((a + HALF) >>> LR);
    endfunction
`else
    // Truncate toward minus infinity.
    function automatic logic signed [dwidth-1:0] scale_out(
        input logic signed [AW-1:0] a
    );
        scale_out = dwidth'(a >>> LR);
    endfunction
`endif

    // -------------------------------------------------------------------------
    // Signals
    // -------------------------------------------------------------------------
    logic signed [dwidth-1:0] latch_re [Nfft];
    logic signed [dwidth-1:0] latch_im [Nfft];
    logic                     load_p0;

    state_t                   state_q;
    state_t                   state_d;
    logic [LR:0]              mu_p1;
    logic [LR:0]              mu_d;
    logic                     ovr_p1;
    logic                     ovr_d;
    logic                     unr_p1;
    logic                     unr_d;
    logic                     step_d;

    logic signed [dwidth-1:0] tgt_re_p1 [Nfft];
    logic signed [dwidth-1:0] tgt_im_p1 [Nfft];
    logic signed [DW1-1:0]    dlt_re_p1 [Nfft];
    logic signed [DW1-1:0]    dlt_im_p1 [Nfft];
    logic signed [AW-1:0]     acc_re_p1 [Nfft];
    logic signed [AW-1:0]     acc_im_p1 [Nfft];

    logic [Nfft-1:0][dwidth-1:0] dout_re_p2;
    logic [Nfft-1:0][dwidth-1:0] dout_im_p2;
    logic                        vld_p2;

    // -------------------------------------------------------------------------
    // Stage p0: burst capture and burst-done detect
    // -------------------------------------------------------------------------

    // The latch bank is not reset. A partial burst is simply overwritten by
    // the next full one. A write in the same cycle as load lands after load
    // has copied the bank, so it belongs to the next burst.
    always_ff @(posedge clk) begin
        if (dv_in) begin
            latch_re[index_in] <= din_real;
            latch_im[index_in] <= din_imag;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            load_p0 <= 1'b0;
        end else begin
            load_p0 <= dv_in && (index_in == IDX_LAST);
        end
    end

    // -------------------------------------------------------------------------
    // Stage p1: ramp control and accumulators
    // -------------------------------------------------------------------------

    // load_p0 has priority over out_ce in every state. A strobe that
    // coincides with a load is dropped and does not count as an underrun.
    always_comb begin
        state_d = state_q;
        mu_d    = mu_p1;
        ovr_d   = 1'b0;
        unr_d   = 1'b0;
        step_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (load_p0) begin
                    state_d = RAMP;
                    mu_d    = '0;
                end else if (out_ce) begin
                    unr_d = 1'b1;
                end
            end
            RAMP: begin
                if (load_p0) begin
                    // Restart from the old target; the mid-ramp value is lost.
                    mu_d  = '0;
                    ovr_d = 1'b1;
                end else if (out_ce) begin
                    step_d = 1'b1;
                    mu_d   = mu_p1 + (LR+1)'(1);
                    if (mu_p1 == MU_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                mu_d    = MU_R;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            mu_p1   <= MU_R;
            ovr_p1  <= 1'b0;
            unr_p1  <= 1'b0;
        end else begin
            state_q <= state_d;
            mu_p1   <= mu_d;
            ovr_p1  <= ovr_d;
            unr_p1  <= unr_d;
        end
    end

    // Targets are cleared so that the first ramp after reset starts from 0.
    // After R steps of delta, acc lands exactly on new_target << LR.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < Nfft; k++) begin
                tgt_re_p1[k] <= '0;
                tgt_im_p1[k] <= '0;
                dlt_re_p1[k] <= '0;
                dlt_im_p1[k] <= '0;
                acc_re_p1[k] <= '0;
                acc_im_p1[k] <= '0;
            end
        end else if (load_p0) begin
            for (int k = 0; k < Nfft; k++) begin
                dlt_re_p1[k] <= lane_delta(latch_re[k], tgt_re_p1[k]);
                dlt_im_p1[k] <= lane_delta(latch_im[k], tgt_im_p1[k]);
                acc_re_p1[k] <= acc_init(tgt_re_p1[k]);
                acc_im_p1[k] <= acc_init(tgt_im_p1[k]);
                tgt_re_p1[k] <= latch_re[k];
                tgt_im_p1[k] <= latch_im[k];
            end
        end else if (step_d) begin
            for (int k = 0; k < Nfft; k++) begin
                acc_re_p1[k] <= acc_step(acc_re_p1[k], dlt_re_p1[k]);
                acc_im_p1[k] <= acc_step(acc_im_p1[k], dlt_im_p1[k]);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage p2: output scaling register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dout_re_p2 <= '0;
            dout_im_p2 <= '0;
            vld_p2     <= 1'b0;
        end else begin
            for (int k = 0; k < Nfft; k++) begin
                dout_re_p2[k] <= scale_out(acc_re_p1[k]);
                dout_im_p2[k] <= scale_out(acc_im_p1[k]);
            end
            vld_p2 <= (state_q != IDLE);
        end
    end

    // phase_out, overrun and underrun come from stage p1. They therefore
    // lead dout by one cycle.
    assign dout_real  = dout_re_p2;
    assign dout_imag  = dout_im_p2;
    assign dout_valid = vld_p2;
    assign phase_out  = mu_p1;
    assign overrun    = ovr_p1;
    assign underrun   = unr_p1;

endmodule

// File: tb/tb_linterp_ramp.sv
`timescale 1ns/1ps
module tb_linterp_ramp;

    localparam int DW = 16;
    localparam int N  = 32;
    localparam int IW = 5;
    localparam int LR = 3;
    localparam int R  = 8;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic                   dv_in;
    logic [IW-1:0]          index_in;
    logic signed [DW-1:0]   din_real;
    logic signed [DW-1:0]   din_imag;
    logic                   out_ce;
    logic [N-1:0][DW-1:0]   dout_real;
    logic [N-1:0][DW-1:0]   dout_imag;
    logic                   dout_valid;
    logic [LR:0]            phase_out;
    logic                   overrun;
    logic                   underrun;

    linterp_ramp #(.dwidth(DW), .Nfft(N), .iwidth(IW), .LR(LR)) dut (
        .clk(clk), .resetn(resetn), .dv_in(dv_in), .index_in(index_in),
        .din_real(din_real), .din_imag(din_imag), .out_ce(out_ce),
        .dout_real(dout_real), .dout_imag(dout_imag), .dout_valid(dout_valid),
        .phase_out(phase_out), .overrun(overrun), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: the previous and current targets plus the step count.
    // The lane value is the closed-form point prev + mu*(tgt-prev)/R.
    int m_prev_re [N];
    int m_prev_im [N];
    int m_tgt_re  [N];
    int m_tgt_im  [N];
    int m_mu;
    int exp_ovr;
    int exp_unr;

    int bre [N];
    int bim [N];

    int ph_e1;
    int ovr_e1;
    int unr_e1;
    int vld_e1;

    typedef struct {
        int kind;      // 0 = uniform burst, 1 = single out_ce strobe
        int re;
        int im;
        int exp_re;
        int exp_im;
        int exp_ph;
        int exp_unr;
    } vec_t;

    vec_t tv[$];

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int model_out(input int p, input int t, input int mu);
        int a;
        a = p * R + mu * (t - p);
`ifdef LINTERP_ROUND_EN
        return fdiv(a + R / 2, R);
`else
        return fdiv(a, R);
`endif
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_lanes(input string name, input int use_model,
                               input int ur, input int ui);
        int bad, er, ei, ar, ai, br, bi, bar, bai;
        bad = -1; br = 0; bi = 0; bar = 0; bai = 0;
        for (int k = 0; k < N; k++) begin
            if (use_model != 0) begin
                er = model_out(m_prev_re[k], m_tgt_re[k], m_mu);
                ei = model_out(m_prev_im[k], m_tgt_im[k], m_mu);
            end else begin
                er = ur;
                ei = ui;
            end
            ar = int'($signed(dout_real[k]));
            ai = int'($signed(dout_imag[k]));
            if (bad < 0 && (ar != er || ai != ei)) begin
                bad = k; br = er; bi = ei; bar = ar; bai = ai;
            end
        end
        n_cmp++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: lane %0d got re=%0d im=%0d, expected re=%0d im=%0d",
                     name, bad, bar, bai, br, bi);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0; dv_in = 1'b0; out_ce = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int k = 0; k < N; k++) begin
            m_prev_re[k] = 0; m_prev_im[k] = 0; m_tgt_re[k] = 0; m_tgt_im[k] = 0;
        end
        m_mu = R;
    endtask

    task automatic check_reset_state(input string name);
        check_lanes({name, "_dout"}, 0, 0, 0);
        check_int({name, "_valid"}, int'(dout_valid), 0);
        check_int({name, "_phase"}, int'(phase_out), R);
        check_int({name, "_ovr"}, int'(overrun), 0);
        check_int({name, "_unr"}, int'(underrun), 0);
    endtask

    // Sends bre/bim as one burst. It returns #1 after E2, the edge at which
    // dout first shows the ramp start. Signals seen after E1 go to *_e1.
    task automatic do_burst(input int ce_on_load, input int extra_wr);
        for (int i = 0; i < N; i++) begin
            dv_in = 1'b1; index_in = IW'(i);
            din_real = DW'(bre[i]); din_imag = DW'(bim[i]);
            @(posedge clk); #1;
        end
        dv_in = 1'b0;
        if (extra_wr != 0) begin
            dv_in = 1'b1; index_in = '0; din_real = 16'sd999; din_imag = -16'sd999;
        end
        out_ce = (ce_on_load != 0);
        @(posedge clk); #1;
        dv_in = 1'b0; out_ce = 1'b0;
        ph_e1 = int'(phase_out); ovr_e1 = int'(overrun);
        unr_e1 = int'(underrun); vld_e1 = int'(dout_valid);
        exp_ovr = (m_mu < R) ? 1 : 0;
        exp_unr = 0;
        for (int k = 0; k < N; k++) begin
            m_prev_re[k] = m_tgt_re[k]; m_prev_im[k] = m_tgt_im[k];
            m_tgt_re[k] = bre[k];       m_tgt_im[k] = bim[k];
        end
        m_mu = 0;
        @(posedge clk); #1;
    endtask

    task automatic strobe();
        out_ce = 1'b1;
        @(posedge clk); #1;
        out_ce = 1'b0;
        ph_e1 = int'(phase_out); ovr_e1 = int'(overrun); unr_e1 = int'(underrun);
        if (m_mu < R) begin
            m_mu++;
            exp_unr = 0;
        end else begin
            exp_unr = 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic check_burst_model(input string name);
        check_int({name, "_phase"}, ph_e1, 0);
        check_int({name, "_ovr"}, ovr_e1, exp_ovr);
        check_int({name, "_unr"}, unr_e1, 0);
        check_int({name, "_valid"}, int'(dout_valid), 1);
        check_lanes({name, "_dout"}, 1, 0, 0);
    endtask

    task automatic check_strobe_model(input string name);
        check_int({name, "_phase"}, ph_e1, m_mu);
        check_int({name, "_unr"}, unr_e1, exp_unr);
        check_int({name, "_ovr"}, ovr_e1, 0);
        check_lanes({name, "_dout"}, 1, 0, 0);
    endtask

    task automatic fill_uniform(input int re, input int im);
        for (int k = 0; k < N; k++) begin
            bre[k] = re; bim[k] = im;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        int t4re [9];
        int t4im [9];
        int nce, ce, ex;
`ifdef LINTERP_ROUND_EN
        t4re = '{0, 0, 1, 1, 2, 2, 2, 3, 3};
        t4im = '{0, 0, -1, -1, -1, -2, -2, -3, -3};
`else
        t4re = '{0, 0, 0, 1, 1, 1, 2, 2, 3};
        t4im = '{0, -1, -1, -2, -2, -2, -3, -3, -3};
`endif
        // First ramp from reset, the ramp back down plus one underrun strobe,
        // then a small step that shows the output rounding.
        v = '{0, 800, -800, 0, 0, 0, 0}; tv.push_back(v);
        for (int i = 1; i <= 8; i++) begin
            v = '{1, 0, 0, 100 * i, -100 * i, i, 0}; tv.push_back(v);
        end
        v = '{0, 0, 0, 800, -800, 0, 0}; tv.push_back(v);
        for (int i = 1; i <= 8; i++) begin
            v = '{1, 0, 0, 800 - 100 * i, -800 + 100 * i, i, 0}; tv.push_back(v);
        end
        v = '{1, 0, 0, 0, 0, 8, 1}; tv.push_back(v);
        v = '{0, 3, -3, 0, 0, 0, 0}; tv.push_back(v);
        for (int i = 1; i <= 8; i++) begin
            v = '{1, 0, 0, t4re[i], t4im[i], i, 0}; tv.push_back(v);
        end

        resetn = 1'b0; dv_in = 1'b0; out_ce = 1'b0; index_in = '0;
        din_real = '0; din_imag = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check_reset_state("reset");

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].kind == 0) begin
                fill_uniform(tv[i].re, tv[i].im);
                do_burst(0, 0);
                check_int($sformatf("tv%0d_vld_e1", i), vld_e1, (i == 0) ? 0 : 1);
                check_int($sformatf("tv%0d_valid", i), int'(dout_valid), 1);
                check_int($sformatf("tv%0d_ovr", i), ovr_e1, 0);
            end else begin
                strobe();
                check_int($sformatf("tv%0d_unr", i), unr_e1, tv[i].exp_unr);
                check_int($sformatf("tv%0d_unr_end", i), int'(underrun), 0);
            end
            check_int($sformatf("tv%0d_phase", i), ph_e1, tv[i].exp_ph);
            check_lanes($sformatf("tv%0d_dout", i), 0, tv[i].exp_re, tv[i].exp_im);
        end

        // Overrun: reload after only 3 strobes. The ramp snaps to the old target.
        fill_uniform(800, 800);
        do_burst(0, 0);
        check_burst_model("ovr_b1");
        repeat (3) begin
            strobe();
            check_strobe_model("ovr_s");
        end
        fill_uniform(0, 0);
        do_burst(0, 0);
        check_int("ovr_pulse", ovr_e1, 1);
        check_int("ovr_pulse_end", int'(overrun), 0);
        check_lanes("ovr_snap", 0, 800, 800);
        for (int i = 0; i < 8; i++) begin
            strobe();
            check_strobe_model("ovr_ramp");
        end
        check_lanes("ovr_final", 0, 0, 0);

        // Reset in the middle of a burst. The partial burst must never load.
        for (int i = 0; i < 20; i++) begin
            dv_in = 1'b1; index_in = IW'(i); din_real = 16'sd777; din_imag = 16'sd777;
            @(posedge clk); #1;
        end
        do_reset();
        check_reset_state("rst_mid");
        repeat (5) @(posedge clk);
        #1;
        check_int("rst_mid_valid_idle", int'(dout_valid), 0);
        fill_uniform(500, -500);
        do_burst(0, 0);
        check_int("rst_mid_vld_e1", vld_e1, 0);
        check_int("rst_mid_valid_e2", int'(dout_valid), 1);
        check_lanes("rst_mid_start", 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            strobe();
            check_strobe_model("rst_mid_ramp");
        end
        check_lanes("rst_mid_final", 0, 500, -500);

        // Strobe on the load cycle plus a write into the next burst at the same
        // time. Each lane gets its own distinct value.
        for (int k = 0; k < N; k++) begin
            bre[k] = 16 * k; bim[k] = -16 * k;
        end
        do_burst(1, 1);
        check_int("coinc_phase", ph_e1, 0);
        check_int("coinc_unr", unr_e1, 0);
        check_int("coinc_ovr", ovr_e1, 0);
        check_lanes("coinc_start", 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            strobe();
            check_strobe_model("coinc_ramp");
        end
        check_int("coinc_lane0", int'($signed(dout_real[0])), 0);
        check_int("coinc_lane31", int'($signed(dout_imag[31])), -496);

        // Randomised bursts and strobe counts, compared with the model.
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < N; k++) begin
                bre[k] = int'($urandom_range(0, 65535)) - 32768;
                bim[k] = int'($urandom_range(0, 65535)) - 32768;
            end
            nce = int'($urandom_range(0, 10));
            ce  = int'($urandom_range(0, 1));
            ex  = int'($urandom_range(0, 1));
            do_burst(ce, ex);
            check_burst_model($sformatf("rnd%0d_load", it));
            for (int s = 0; s < nce; s++) begin
                strobe();
                check_strobe_model($sformatf("rnd%0d_s%0d", it, s));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
